// File: rtl/interface_mux_pkg.sv
// ---------------------------------------------------------------------------
// interface_mux_pkg : shared FSM states and pointer-word field positions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package interface_mux_pkg;

    localparam int MAX_PORTS   = 16;
    localparam int CRC_ERR_BIT = 15;
    localparam int LEN_ERR_BIT = 14;
    localparam int ERR_OUT_BIT = 11;
    localparam int PORT_LSB    = 12;
    localparam int LEN_MSB     = 10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_PTR_RD  = 3'd2,
        S_PTR_LAT = 3'd3,
        S_SPACE   = 3'd4,
        S_XFER    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n : combinational round-robin pick, searching upward from
// last_grant+1 modulo NUM_PORTS.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_n #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PORT_W-1:0]    i_last_grant,
    output logic [PORT_W-1:0]    o_grant,
    output logic                 o_valid
);

    logic [PORT_W:0] w_sum;

    // Walk the offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_sum   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_sum = {1'b0, i_last_grant} + (PORT_W+1)'(k);
            if (w_sum >= (PORT_W+1)'(NUM_PORTS))
                w_sum = w_sum - (PORT_W+1)'(NUM_PORTS);
            if (i_req[w_sum[PORT_W-1:0]]) begin
                o_valid = 1'b1;
                o_grant = w_sum[PORT_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/interface_mux_n.sv
// ---------------------------------------------------------------------------
// interface_mux_n : round-robin drain of NUM_PORTS EMAC rx FIFO pairs into one
// switch FIFO pair. Optional macro IFMUX_DROP_ERR_EN discards error frames.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module interface_mux_n
    import interface_mux_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int LEN_W     = 11,
    parameter int FREE_W    = 12
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_PORTS-1:0]     rx_ptr_fifo_empty,
    output logic [NUM_PORTS-1:0]     rx_ptr_fifo_rd,
    input  logic [16*NUM_PORTS-1:0]  rx_ptr_fifo_dout,
    output logic [NUM_PORTS-1:0]     rx_data_fifo_rd,
    input  logic [8*NUM_PORTS-1:0]   rx_data_fifo_dout,
    input  logic [FREE_W-1:0]        sfifo_free,
    output logic                     sfifo_wr,
    output logic [7:0]               sfifo_din,
    input  logic                     ptr_sfifo_full,
    output logic                     ptr_sfifo_wr,
    output logic [15:0]              ptr_sfifo_din,
    output logic                     frame_drop
);

    localparam int CMP_W = (FREE_W > LEN_W) ? FREE_W : LEN_W;

    state_t                r_state;
    logic [PORT_W-1:0]     r_grant;
    logic [PORT_W-1:0]     r_last_grant;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_err;
    logic                  r_drop;
    logic [NUM_PORTS-1:0]  r_ptr_rd;
    logic [NUM_PORTS-1:0]  r_data_rd;
    logic                  r_sfifo_wr;
    logic [7:0]            r_sfifo_din;
    logic                  r_ptr_sfifo_wr;
    logic [15:0]           r_ptr_sfifo_din;
    logic                  r_frame_drop;

    logic [NUM_PORTS-1:0]  w_req;
    logic [PORT_W-1:0]     w_arb_grant;
    logic                  w_arb_valid;
    logic [LEN_W-1:0]      w_ptr_len;
    logic                  w_ptr_err;
    logic [7:0]            w_data_sel;
    logic                  w_space_ok;
    logic                  w_drop_now;
    logic [15:0]           w_out_ptr;

    assign w_req = ~rx_ptr_fifo_empty;

    rr_arbiter_n #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_arb (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_valid      (w_arb_valid)
    );

    always_comb begin
        w_ptr_len  = '0;
        w_ptr_err  = 1'b0;
        w_data_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == PORT_W'(p)) begin
                w_ptr_len  = rx_ptr_fifo_dout[16*p +: LEN_W];
                w_ptr_err  = rx_ptr_fifo_dout[16*p + CRC_ERR_BIT]
                           | rx_ptr_fifo_dout[16*p + LEN_ERR_BIT];
                w_data_sel = rx_data_fifo_dout[8*p +: 8];
            end
        end
    end

    always_comb begin
        w_out_ptr                  = '0;
        w_out_ptr[PORT_LSB +: 4]   = 4'(r_grant);
        w_out_ptr[ERR_OUT_BIT]     = r_err;
        w_out_ptr[LEN_MSB:0]       = r_len;
    end

    // Whole frame must fit before any byte is read, so no partial frame lands.
    assign w_space_ok = (CMP_W'(sfifo_free) >= CMP_W'(r_len)) && !ptr_sfifo_full;

`ifdef IFMUX_DROP_ERR_EN
    assign w_drop_now = w_ptr_err;
`else
    assign w_drop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_last_grant    <= PORT_W'(NUM_PORTS-1);
            r_len           <= '0;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            r_drop          <= 1'b0;
            r_ptr_rd        <= '0;
            r_data_rd       <= '0;
            r_sfifo_wr      <= 1'b0;
            r_sfifo_din     <= '0;
            r_ptr_sfifo_wr  <= 1'b0;
            r_ptr_sfifo_din <= '0;
            r_frame_drop    <= 1'b0;
        end else begin
            r_sfifo_wr     <= (|r_data_rd) && !r_drop;
            if (|r_data_rd)
                r_sfifo_din <= w_data_sel;
            r_ptr_sfifo_wr <= 1'b0;
            r_frame_drop   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (|w_req)
                        r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_arb_valid) begin
                        r_grant  <= w_arb_grant;
                        r_ptr_rd <= NUM_PORTS'(1) << w_arb_grant;
                        r_state  <= S_PTR_RD;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_PTR_RD: begin
                    r_ptr_rd <= '0;
                    r_state  <= S_PTR_LAT;
                end
                S_PTR_LAT: begin
                    r_len   <= w_ptr_len;
                    r_cnt   <= w_ptr_len;
                    r_err   <= w_ptr_err;
                    r_drop  <= w_drop_now;
                    r_state <= S_SPACE;
                end
                S_SPACE: begin
                    if (r_len == '0) begin
                        r_last_grant <= r_grant;
                        r_state      <= S_ARB;
                    end else if (r_drop || w_space_ok) begin
                        r_data_rd <= NUM_PORTS'(1) << r_grant;
                        r_state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == LEN_W'(1)) begin
                        r_data_rd    <= '0;
                        r_frame_drop <= r_drop;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ptr_sfifo_wr  <= !r_drop;
                    r_ptr_sfifo_din <= w_out_ptr;
                    r_last_grant    <= r_grant;
                    r_state         <= (|w_req) ? S_ARB : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_ptr_fifo_rd  = r_ptr_rd;
    assign rx_data_fifo_rd = r_data_rd;
    assign sfifo_wr        = r_sfifo_wr;
    assign sfifo_din       = r_sfifo_din;
    assign ptr_sfifo_wr    = r_ptr_sfifo_wr;
    assign ptr_sfifo_din   = r_ptr_sfifo_din;
    assign frame_drop      = r_frame_drop;

endmodule

`default_nettype wire

// File: tb/tb_interface_mux_n.sv
// ---------------------------------------------------------------------------
// tb_interface_mux_n : directed bench with behavioural per-port FIFOs
// (pointer FIFO registered-read, data FIFO show-ahead).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_interface_mux_n;
    import interface_mux_pkg::*;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int LW = 11;
    localparam int FW = 12;
`ifdef IFMUX_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [NP-1:0]   ptr_empty = '1;
    logic [NP-1:0]   ptr_rd;
    logic [16*NP-1:0] ptr_dout = '0;
    logic [NP-1:0]   data_rd;
    logic [8*NP-1:0] data_dout = '0;
    logic [FW-1:0]   free = 12'd2000;
    logic            sfifo_wr;
    logic [7:0]      sfifo_din;
    logic            ptr_full = 1'b0;
    logic            ptr_wr;
    logic [15:0]     ptr_din;
    logic            frame_drop;

    always #5 clk = ~clk;

    interface_mux_n #(
        .NUM_PORTS (NP), .PORT_W (PW), .LEN_W (LW), .FREE_W (FW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .rx_ptr_fifo_empty (ptr_empty),
        .rx_ptr_fifo_rd    (ptr_rd),
        .rx_ptr_fifo_dout  (ptr_dout),
        .rx_data_fifo_rd   (data_rd),
        .rx_data_fifo_dout (data_dout),
        .sfifo_free        (free),
        .sfifo_wr          (sfifo_wr),
        .sfifo_din         (sfifo_din),
        .ptr_sfifo_full    (ptr_full),
        .ptr_sfifo_wr      (ptr_wr),
        .ptr_sfifo_din     (ptr_din),
        .frame_drop        (frame_drop)
    );

    logic [15:0] pq [NP][$];
    logic [7:0]  dq [NP][$];
    logic [7:0]  exp_data [$];
    logic [7:0]  got_data [$];
    logic [15:0] got_ptr  [$];
    int          ptr_cyc  [$];
    int          rd_cnt [NP];
    int          drop_cnt, multi_rd, first_rd_cyc;
    int          cyc = 0;
    int          n_vec = 0, n_err = 0;

    // Upstream FIFO pops happen on the clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int p = 0; p < NP; p++) begin
            if (ptr_rd[p] && pq[p].size() > 0)
                ptr_dout[16*p +: 16] <= pq[p].pop_front();
            if (data_rd[p] && dq[p].size() > 0)
                void'(dq[p].pop_front());
        end
    end

    // Refresh FIFO flags/outputs and observe the DUT half a cycle off the edge.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            ptr_empty[p] = (pq[p].size() == 0);
            data_dout[8*p +: 8] = (dq[p].size() > 0) ? dq[p][0] : 8'h00;
            if (data_rd[p]) rd_cnt[p]++;
        end
        if (sfifo_wr) got_data.push_back(sfifo_din);
        if (ptr_wr) begin
            got_ptr.push_back(ptr_din);
            ptr_cyc.push_back(cyc);
        end
        if ($countones({ptr_rd, data_rd}) > 1) multi_rd++;
        if ((|data_rd) && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (frame_drop) drop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] fbyte(input int seed, input int i);
        if (seed == 0 && i < 6) return 8'hf0 + 8'(i);
        return 8'(seed * 37 + i);
    endfunction

    function automatic logic [31:0] ptr_at(input int i);
        if (i < got_ptr.size()) return 32'(got_ptr[i]);
        return 32'hdead_beef;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < ptr_cyc.size()) return ptr_cyc[i];
        return -100000;
    endfunction

    task automatic clear_obs();
        exp_data.delete();
        got_data.delete();
        got_ptr.delete();
        ptr_cyc.delete();
        for (int p = 0; p < NP; p++) rd_cnt[p] = 0;
        drop_cnt     = 0;
        first_rd_cyc = -1;
    endtask

    task automatic clear_fifos();
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            dq[p].delete();
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_fifos();
        tick(3);
        clear_obs();
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic push_frame(input int port, input logic [15:0] ptr, input int seed, input bit fwd);
        pq[port].push_back(ptr);
        for (int i = 0; i < int'(ptr[10:0]); i++) begin
            dq[port].push_back(fbyte(seed, i));
            if (fwd) exp_data.push_back(fbyte(seed, i));
        end
    endtask

    task automatic cmp_stream(input string tag);
        int nbad = 0;
        int n    = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        check({tag, "_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < n; i++)
            if (got_data[i] !== exp_data[i]) nbad++;
        check({tag, "_bytes"}, nbad, 0);
    endtask

    initial begin
        multi_rd = 0;
        clear_obs();
        tick(3);
        check("rst_strobes", {ptr_rd, data_rd, sfifo_wr, ptr_wr, frame_drop}, 0);
        check("rst_din", {sfifo_din, ptr_din}, 0);

        // Single 104-byte frame on port 0, DA f0..f5
        do_reset();
        push_frame(0, 16'h0068, 0, 1'b1);
        tick(150);
        cmp_stream("t1");
        check("t1_da0", got_data.size() > 5 ? 32'(got_data[0]) : 32'h0, 32'hf0);
        check("t1_da5", got_data.size() > 5 ? 32'(got_data[5]) : 32'h0, 32'hf5);
        check("t1_nptr", got_ptr.size(), 1);
        check("t1_ptr", ptr_at(0), 32'h0068);

        // Two frames each on ports 0 and 1: strict alternation, len+5 spacing
        do_reset();
        push_frame(0, 16'h0068, 1, 1'b1);
        push_frame(1, 16'h0068, 2, 1'b1);
        push_frame(0, 16'h0068, 3, 1'b1);
        push_frame(1, 16'h0068, 4, 1'b1);
        tick(480);
        cmp_stream("t2");
        check("t2_nptr", got_ptr.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t2_ptr", ptr_at(i), (i % 2 == 1) ? 32'h1068 : 32'h0068);
        check("t2_gap", cyc_at(1) - cyc_at(0), 109);

        // CRC-error frame on port 1
        do_reset();
        push_frame(1, 16'h8068, 5, !DROP);
        tick(150);
        check("t3_rd", rd_cnt[1], 104);
        if (DROP) begin
            check("t3_wr", got_data.size(), 0);
            check("t3_nptr", got_ptr.size(), 0);
            check("t3_drop", drop_cnt, 1);
        end else begin
            cmp_stream("t3");
            check("t3_ptr", ptr_at(0), 32'h1868);
            check("t3_drop", drop_cnt, 0);
        end

        // Insufficient free space holds off the transfer
        do_reset();
        free = 12'd50;
        push_frame(0, 16'h0068, 6, 1'b1);
        tick(30);
        check("t4_stall", rd_cnt[0], 0);
        begin
            int raise_cyc;
            raise_cyc = cyc;
            free = 12'd104;
            tick(150);
            check("t4_lat", first_rd_cyc, raise_cyc + 1);
        end
        cmp_stream("t4");
        check("t4_ptr", ptr_at(0), 32'h0068);
        free = 12'd2000;

        // Zero-length pointer on port 2, then a frame on port 3
        do_reset();
        push_frame(2, 16'h0000, 0, 1'b1);
        push_frame(3, 16'h0068, 7, 1'b1);
        tick(160);
        check("t5_pop", pq[2].size(), 0);
        check("t5_rd2", rd_cnt[2], 0);
        check("t5_nptr", got_ptr.size(), 1);
        check("t5_ptr", ptr_at(0), 32'h3068);
        cmp_stream("t5");

        // Reset in the middle of a frame
        do_reset();
        push_frame(0, 16'h0068, 8, 1'b1);
        for (int i = 0; i < 200 && got_data.size() < 40; i++) tick(1);
        check("t6_reach", got_data.size() >= 40, 1);
        rstn = 1'b0;
        clear_fifos();
        tick(1);
        check("t6_strobes", {ptr_rd, data_rd, sfifo_wr, ptr_wr, frame_drop}, 0);
        check("t6_state", 32'(dut.r_state), 32'(S_IDLE));
        tick(1);
        clear_obs();
        rstn = 1'b1;
        push_frame(1, 16'h0068, 9, 1'b1);
        tick(150);
        cmp_stream("t6");
        check("t6_ptr", ptr_at(0), 32'h1068);

        check("rd_onehot", multi_rd, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
